// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encodings, port indices
// and default widths.
package dmem_arbiter_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LDR = 1'b1;

  localparam int DEF_ADDR_W   = 10;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_MAX_WAIT = 8;
  localparam int WAIT_W       = 8;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-way round-robin selector. A non-zero one-hot force_i overrides the
// round-robin choice and grants only the forced port (if it requests).
module rr_pick2
  import dmem_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  input  logic [1:0] force_i,
  output logic [1:0] gnt_o
);

  // Grant selection: forced port, else the port that did not win last time.
  always_comb begin
    gnt_o = 2'b00;
    if (force_i != 2'b00) begin
      gnt_o = req_i & force_i;
    end else begin
      case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = (last_i == PORT_CPU) ? 2'b10 : 2'b01;
        default: gnt_o = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a single-port data memory between the processor (port 0) and a
// loader/debug master (port 1) with round-robin, lock bursts and a starvation bound.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  input  logic              m1_lock,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

  state_e            state_q, state_d;
  logic              last_q, last_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              rearm_q, rearm_d;
  logic              rd_valid_q, rd_valid_d;
  logic              rd_owner_q, rd_owner_d;
  logic              brk_s;
  logic [1:0]        force_s;
  logic [1:0]        pick_s;
  logic [1:0]        gnt_s;

  // Lock gives port 1 exclusive priority; the starvation break forces port 0.
  always_comb begin
    brk_s   = (state_q == ST_LOCKED) && (wait_q == MAX_WAIT_C);
    force_s = 2'b00;
    if (state_q == ST_LOCKED) begin
      force_s = brk_s ? 2'b01 : 2'b10;
    end else begin
      force_s = 2'b00;
    end
  end

  rr_pick2 u_pick (
    .req_i   ({m1_req, m0_req}),
    .last_i  (last_q),
    .force_i (force_s),
    .gnt_o   (pick_s)
  );

  // No grant while reset is asserted, so a write in that cycle never commits.
  assign gnt_s  = rst_n ? pick_s : 2'b00;
  assign m0_gnt = gnt_s[0];
  assign m1_gnt = gnt_s[1];

  // Memory port mirrors the granted requester, zero when idle.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = {ADDR_W{1'b0}};
    mem_wdata = {DATA_W{1'b0}};
    if (gnt_s[1]) begin
      mem_en    = 1'b1;
      mem_we    = m1_we;
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
    end else if (gnt_s[0]) begin
      mem_en    = 1'b1;
      mem_we    = m0_we;
      mem_addr  = m0_addr;
      mem_wdata = m0_wdata;
    end else begin
      mem_en    = 1'b0;
    end
  end

  // Next-state logic: FSM, round-robin history, starvation counter, read tag.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    wait_d     = {WAIT_W{1'b0}};
    rearm_d    = rearm_q;
    rd_valid_d = 1'b0;
    rd_owner_d = rd_owner_q;
    if (gnt_s != 2'b00) begin
      last_d     = gnt_s[1];
      rd_valid_d = ~mem_we;
      rd_owner_d = gnt_s[1];
    end else begin
      last_d     = last_q;
    end
    // After a starvation break, lock must be seen low before it can re-engage.
    if (!m1_lock) begin
      rearm_d = 1'b0;
    end else begin
      rearm_d = rearm_q;
    end
    case (state_q)
      ST_IDLE: begin
        if (gnt_s[1] && m1_lock && !rearm_q) begin
          state_d = ST_LOCKED;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOCKED: begin
        if (brk_s) begin
          state_d = ST_IDLE;
          rearm_d = m1_lock;
        end else if (!m1_lock) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_LOCKED;
          wait_d  = m0_req ? (wait_q + 8'd1) : {WAIT_W{1'b0}};
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      last_q     <= PORT_LDR;
      wait_q     <= {WAIT_W{1'b0}};
      rearm_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_owner_q <= PORT_CPU;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      wait_q     <= wait_d;
      rearm_q    <= rearm_d;
      rd_valid_q <= rd_valid_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  assign m0_rvalid = rd_valid_q && (rd_owner_q == PORT_CPU);
  assign m1_rvalid = rd_valid_q && (rd_owner_q == PORT_LDR);
  assign m0_rdata  = m0_rvalid ? mem_rdata : {DATA_W{1'b0}};
  assign m1_rdata  = m1_rvalid ? mem_rdata : {DATA_W{1'b0}};

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: dut_a uses MAX_WAIT=8, dut_b uses MAX_WAIT=3.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m0_we, m1_req, m1_we, m1_lock;
  logic [9:0]  m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;

  logic        a_m0_gnt, a_m0_rvalid, a_m1_gnt, a_m1_rvalid, a_mem_en, a_mem_we;
  logic [31:0] a_m0_rdata, a_m1_rdata, a_mem_wdata, a_mem_rdata;
  logic [9:0]  a_mem_addr;
  logic        b_m0_gnt, b_m0_rvalid, b_m1_gnt, b_m1_rvalid, b_mem_en, b_mem_we;
  logic [31:0] b_m0_rdata, b_m1_rdata, b_mem_wdata, b_mem_rdata;
  logic [9:0]  b_mem_addr;

  logic [31:0] ram_a [0:15];
  logic [31:0] ram_b [0:15];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(10), .DATA_W(32), .MAX_WAIT(8)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(a_m0_gnt), .m0_rvalid(a_m0_rvalid), .m0_rdata(a_m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(a_m1_gnt), .m1_rvalid(a_m1_rvalid), .m1_rdata(a_m1_rdata),
    .m1_lock(m1_lock),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
  );

  dmem_arbiter #(.ADDR_W(10), .DATA_W(32), .MAX_WAIT(3)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(b_m0_gnt), .m0_rvalid(b_m0_rvalid), .m0_rdata(b_m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(b_m1_gnt), .m1_rvalid(b_m1_rvalid), .m1_rdata(b_m1_rdata),
    .m1_lock(m1_lock),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
  );

  // Synchronous single-port RAM models, one per DUT.
  always @(posedge clk) begin
    if (a_mem_en) begin
      if (a_mem_we) ram_a[a_mem_addr[3:0]] <= a_mem_wdata;
      else a_mem_rdata <= ram_a[a_mem_addr[3:0]];
    end
    if (b_mem_en) begin
      if (b_mem_we) ram_b[b_mem_addr[3:0]] <= b_mem_wdata;
      else b_mem_rdata <= ram_b[b_mem_addr[3:0]];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r0, input logic w0, input logic [9:0] a0, input logic [31:0] d0,
                       input logic r1, input logic w1, input logic [9:0] a1, input logic [31:0] d1,
                       input logic lk);
    m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
    m1_lock = lk;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 10'd2, 32'd0, 1'b1, 1'b0, 10'd3, 32'd0, 1'b0);
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++; if (a_m0_gnt !== 1'b0) begin failures++; $display("FAIL rst_m0_gnt got=%b exp=0", a_m0_gnt); end
      checks++; if (a_m1_gnt !== 1'b0) begin failures++; $display("FAIL rst_m1_gnt got=%b exp=0", a_m1_gnt); end
      checks++; if (a_mem_en !== 1'b0) begin failures++; $display("FAIL rst_mem_en got=%b exp=0", a_mem_en); end
      checks++; if (a_mem_addr !== 10'd0) begin failures++; $display("FAIL rst_mem_addr got=%0d exp=0", a_mem_addr); end
      checks++; if ({a_m0_rvalid, a_m1_rvalid} !== 2'b00) begin failures++; $display("FAIL rst_rvalid got=%b exp=00", {a_m0_rvalid, a_m1_rvalid}); end
      step();
    end
    rst_n = 1'b1;
    #1;
    checks++; if ({a_m1_gnt, a_m0_gnt} !== 2'b01) begin failures++; $display("FAIL rel_first_gnt got=%b exp=01", {a_m1_gnt, a_m0_gnt}); end
    checks++; if (a_mem_addr !== 10'd2) begin failures++; $display("FAIL rel_mem_addr got=%0d exp=2", a_mem_addr); end
    step();
  endtask

  task automatic test_alternation();
    for (int i = 1; i <= 4; i++) begin
      #1;
      checks++; if ({a_m1_gnt, a_m0_gnt} !== ((i % 2 == 1) ? 2'b10 : 2'b01)) begin failures++; $display("FAIL alt_gnt[%0d] got=%b", i, {a_m1_gnt, a_m0_gnt}); end
      if (i % 2 == 1) begin
        checks++; if ({a_m1_rvalid, a_m0_rvalid} !== 2'b01 || a_m0_rdata !== 32'hA000_0002 || a_m1_rdata !== 32'd0) begin
          failures++; $display("FAIL alt_ret0[%0d] got rv=%b d0=%h d1=%h exp rv=01 d0=a0000002", i, {a_m1_rvalid, a_m0_rvalid}, a_m0_rdata, a_m1_rdata); end
      end else begin
        checks++; if ({a_m1_rvalid, a_m0_rvalid} !== 2'b10 || a_m1_rdata !== 32'hA000_0003 || a_m0_rdata !== 32'd0) begin
          failures++; $display("FAIL alt_ret1[%0d] got rv=%b d0=%h d1=%h exp rv=10 d1=a0000003", i, {a_m1_rvalid, a_m0_rvalid}, a_m0_rdata, a_m1_rdata); end
      end
      step();
    end
    drive(1'b0, 1'b0, 10'd0, 32'd0, 1'b0, 1'b0, 10'd0, 32'd0, 1'b0);
    #1;
    checks++; if (a_m0_rvalid !== 1'b1 || a_m0_rdata !== 32'hA000_0002) begin failures++; $display("FAIL alt_last_ret got rv=%b d=%h exp rv=1 d=a0000002", a_m0_rvalid, a_m0_rdata); end
    checks++; if (a_mem_en !== 1'b0) begin failures++; $display("FAIL alt_idle_en got=%b exp=0", a_mem_en); end
    step();
  endtask

  task automatic test_write_read();
    drive(1'b1, 1'b1, 10'd2, 32'hDEAD_BEEF, 1'b0, 1'b0, 10'd0, 32'd0, 1'b0);
    #1;
    checks++; if (a_m0_gnt !== 1'b1 || a_mem_we !== 1'b1 || a_mem_wdata !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL wr_issue got gnt=%b we=%b wd=%h exp 1 1 deadbeef", a_m0_gnt, a_mem_we, a_mem_wdata); end
    step();
    drive(1'b1, 1'b0, 10'd2, 32'd0, 1'b0, 1'b0, 10'd0, 32'd0, 1'b0);
    #1;
    checks++; if (a_m0_gnt !== 1'b1 || a_mem_we !== 1'b0) begin failures++; $display("FAIL rd_issue got gnt=%b we=%b exp 1 0", a_m0_gnt, a_mem_we); end
    step();
    drive(1'b0, 1'b0, 10'd0, 32'd0, 1'b1, 1'b0, 10'd2, 32'd0, 1'b0);
    #1;
    checks++; if (a_m0_rvalid !== 1'b1 || a_m0_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL wr_rd_m0 got rv=%b d=%h exp 1 deadbeef", a_m0_rvalid, a_m0_rdata); end
    checks++; if (a_m1_gnt !== 1'b1) begin failures++; $display("FAIL wr_rd_m1_gnt got=%b exp=1", a_m1_gnt); end
    step();
    drive(1'b0, 1'b0, 10'd0, 32'd0, 1'b0, 1'b0, 10'd0, 32'd0, 1'b0);
    #1;
    checks++; if (a_m1_rvalid !== 1'b1 || a_m1_rdata !== 32'hDEAD_BEEF || a_m0_rvalid !== 1'b0) begin
      failures++; $display("FAIL wr_rd_m1 got rv1=%b d=%h rv0=%b exp 1 deadbeef 0", a_m1_rvalid, a_m1_rdata, a_m0_rvalid); end
    step();
  endtask

  task automatic test_lock_burst();
    drive(1'b1, 1'b0, 10'd4, 32'd0, 1'b0, 1'b0, 10'd0, 32'd0, 1'b0);
    #1;
    checks++; if (a_m0_gnt !== 1'b1) begin failures++; $display("FAIL lock_pre_gnt got=%b exp=1", a_m0_gnt); end
    step();
    for (int k = 1; k <= 5; k++) begin
      drive(1'b1, 1'b0, 10'd4, 32'd0, 1'b1, 1'b1, 10'(k - 1), 32'h100 + 32'(k), 1'b1);
      #1;
      checks++; if ({a_m1_gnt, a_m0_gnt} !== 2'b10 || a_mem_addr !== 10'(k - 1) || a_mem_we !== 1'b1) begin
        failures++; $display("FAIL lock_burst[%0d] got gnt=%b addr=%0d we=%b exp 10 %0d 1", k, {a_m1_gnt, a_m0_gnt}, a_mem_addr, a_mem_we, k - 1); end
      step();
    end
    drive(1'b1, 1'b0, 10'd4, 32'd0, 1'b0, 1'b0, 10'd0, 32'd0, 1'b0);
    #1;
    checks++; if ({a_m1_gnt, a_m0_gnt} !== 2'b00) begin failures++; $display("FAIL lock_drop_cycle got=%b exp=00", {a_m1_gnt, a_m0_gnt}); end
    step();
    #1;
    checks++; if (a_m0_gnt !== 1'b1) begin failures++; $display("FAIL lock_after_gnt got=%b exp=1", a_m0_gnt); end
    step();
    drive(1'b0, 1'b0, 10'd0, 32'd0, 1'b0, 1'b0, 10'd0, 32'd0, 1'b0);
    #1;
    checks++; if (a_m0_rvalid !== 1'b1 || a_m0_rdata !== 32'h0000_0105) begin failures++; $display("FAIL lock_wr_data got rv=%b d=%h exp 1 00000105", a_m0_rvalid, a_m0_rdata); end
    step();
  endtask

  task automatic test_starvation();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 10'd0, 32'd0, 1'b0, 1'b0, 10'd0, 32'd0, 1'b0);
    step();
    step();
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 10'd1, 32'd0, 1'b1, 1'b0, 10'd3, 32'd0, 1'b1);
    #1;
    checks++; if ({b_m1_gnt, b_m0_gnt} !== 2'b10) begin failures++; $display("FAIL starve_enter got=%b exp=10", {b_m1_gnt, b_m0_gnt}); end
    step();
    drive(1'b1, 1'b0, 10'd1, 32'd0, 1'b1, 1'b0, 10'd3, 32'd0, 1'b1);
    for (int c = 1; c <= 3; c++) begin
      #1;
      checks++; if ({b_m1_gnt, b_m0_gnt} !== 2'b10) begin failures++; $display("FAIL starve_deny[%0d] got=%b exp=10", c, {b_m1_gnt, b_m0_gnt}); end
      step();
    end
    #1;
    checks++; if ({b_m1_gnt, b_m0_gnt} !== 2'b01) begin failures++; $display("FAIL starve_break got=%b exp=01", {b_m1_gnt, b_m0_gnt}); end
    step();
    #1;
    checks++; if ({b_m1_gnt, b_m0_gnt} !== 2'b10) begin failures++; $display("FAIL starve_idle_m1 got=%b exp=10", {b_m1_gnt, b_m0_gnt}); end
    step();
    #1;
    checks++; if ({b_m1_gnt, b_m0_gnt} !== 2'b01) begin failures++; $display("FAIL starve_no_relock got=%b exp=01", {b_m1_gnt, b_m0_gnt}); end
    step();
    drive(1'b1, 1'b0, 10'd1, 32'd0, 1'b0, 1'b0, 10'd3, 32'd0, 1'b0);
    #1;
    checks++; if ({b_m1_gnt, b_m0_gnt} !== 2'b01) begin failures++; $display("FAIL starve_lock_low got=%b exp=01", {b_m1_gnt, b_m0_gnt}); end
    step();
    drive(1'b1, 1'b0, 10'd1, 32'd0, 1'b1, 1'b0, 10'd3, 32'd0, 1'b1);
    #1;
    checks++; if ({b_m1_gnt, b_m0_gnt} !== 2'b10) begin failures++; $display("FAIL starve_relock got=%b exp=10", {b_m1_gnt, b_m0_gnt}); end
    step();
    #1;
    checks++; if ({b_m1_gnt, b_m0_gnt} !== 2'b10) begin failures++; $display("FAIL starve_locked_again got=%b exp=10", {b_m1_gnt, b_m0_gnt}); end
    step();
  endtask

  task automatic test_mid_reset();
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 10'd2, 32'd0, 1'b0, 1'b0, 10'd0, 32'd0, 1'b0);
    #1;
    checks++; if (a_m0_gnt !== 1'b0 || a_mem_en !== 1'b0) begin failures++; $display("FAIL midrst_rd got gnt=%b en=%b exp 0 0", a_m0_gnt, a_mem_en); end
    step();
    drive(1'b1, 1'b1, 10'd7, 32'h0000_0077, 1'b0, 1'b0, 10'd0, 32'd0, 1'b0);
    #1;
    checks++; if (a_mem_en !== 1'b0 || a_mem_we !== 1'b0) begin failures++; $display("FAIL midrst_wr got en=%b we=%b exp 0 0", a_mem_en, a_mem_we); end
    step();
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 10'd0, 32'd0, 1'b0, 1'b0, 10'd0, 32'd0, 1'b0);
    #1;
    checks++; if (a_m0_rvalid !== 1'b0 || a_m0_rdata !== 32'd0) begin failures++; $display("FAIL midrst_rvalid got rv=%b d=%h exp 0 0", a_m0_rvalid, a_m0_rdata); end
    step();
    drive(1'b1, 1'b0, 10'd7, 32'd0, 1'b0, 1'b0, 10'd0, 32'd0, 1'b0);
    #1;
    checks++; if (a_m0_gnt !== 1'b1) begin failures++; $display("FAIL midrst_post_gnt got=%b exp=1", a_m0_gnt); end
    step();
    drive(1'b0, 1'b0, 10'd0, 32'd0, 1'b0, 1'b0, 10'd0, 32'd0, 1'b0);
    #1;
    checks++; if (a_m0_rvalid !== 1'b1 || a_m0_rdata !== 32'hA000_0007) begin failures++; $display("FAIL midrst_no_write got rv=%b d=%h exp 1 a0000007", a_m0_rvalid, a_m0_rdata); end
    step();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      ram_a[i] = 32'hA000_0000 + 32'(i);
      ram_b[i] = 32'hA000_0000 + 32'(i);
    end
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 10'd0, 32'd0, 1'b0, 1'b0, 10'd0, 32'd0, 1'b0);
    step();
    test_reset();
    test_alternation();
    test_write_read();
    test_lock_burst();
    test_starvation();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
